// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the IFU (read-only) and the LSU (read/write),
// inserting LATENCY wait states before each access. Define MEM_ARB_RR_EN for round-robin grant.
module mem_arbiter #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_wr,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wstrb,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned SW    = 4;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;
  localparam bit   HAS_WAIT = (LATENCY > 0);
  localparam logic OWN_IFU  = 1'b0;
  localparam logic OWN_LSU  = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [SW-1:0]    wstrb_q, wstrb_d;
  logic             wr_q, wr_d;
  logic             owner_q, owner_d;
  logic [DW-1:0]    ifu_rdata_q, ifu_rdata_d;
  logic [DW-1:0]    lsu_rdata_q, lsu_rdata_d;
  logic             can_accept;
  logic             grant_lsu;
  logic             accept;

`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;

  // Remember who was granted most recently so contention alternates
  always_comb begin
    last_d = last_q;
    if (accept) last_d = lsu_req_ready ? OWN_LSU : OWN_IFU;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) last_q <= OWN_IFU;
    else        last_q <= last_d;
  end
`endif

  // Grant: accepts only while idle or in the response cycle; reset forces ready low
  always_comb begin
    can_accept = reset && ((state_q == S_IDLE) || (state_q == S_RESP));
    grant_lsu  = lsu_req_valid;
`ifdef MEM_ARB_RR_EN
    if (ifu_req_valid && lsu_req_valid) grant_lsu = (last_q == OWN_IFU);
`endif
    lsu_req_ready = can_accept && lsu_req_valid && grant_lsu;
    ifu_req_ready = can_accept && ifu_req_valid && !grant_lsu;
    accept        = lsu_req_ready || ifu_req_ready;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE:   state_d = S_IDLE;
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_ACCESS;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (accept) begin
      state_d = HAS_WAIT ? S_WAIT : S_ACCESS;
      cnt_d   = CNT_INIT;
    end
  end

  // Request latch and per-requester read data capture
  always_comb begin
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    wr_d        = wr_q;
    owner_d     = owner_q;
    ifu_rdata_d = ifu_rdata_q;
    lsu_rdata_d = lsu_rdata_q;
    if (state_q == S_ACCESS) begin
      if (owner_q == OWN_LSU) lsu_rdata_d = wr_q ? '0 : mem_rdata;
      else                    ifu_rdata_d = mem_rdata;
    end
    if (lsu_req_ready) begin
      owner_d = OWN_LSU;
      addr_d  = lsu_addr;
      wr_d    = lsu_wr;
      wdata_d = lsu_wdata;
      wstrb_d = lsu_wstrb;
    end else if (ifu_req_ready) begin
      owner_d = OWN_IFU;
      addr_d  = ifu_addr;
      wr_d    = 1'b0;
      wdata_d = '0;
      wstrb_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wr_q        <= 1'b0;
      owner_q     <= OWN_IFU;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
    end else begin
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      wr_q        <= wr_d;
      owner_q     <= owner_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
    end
  end

  // Memory strobes only during the access cycle; address/data always show the latch
  always_comb begin
    mem_en         = (state_q == S_ACCESS);
    mem_wr         = mem_en && wr_q;
    mem_wstrb      = mem_en ? wstrb_q : '0;
    mem_addr       = addr_q;
    mem_wdata      = wdata_q;
    ifu_resp_valid = (state_q == S_RESP) && (owner_q == OWN_IFU);
    lsu_resp_valid = (state_q == S_RESP) && (owner_q == OWN_LSU);
    ifu_rdata      = ifu_rdata_q;
    lsu_rdata      = lsu_rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (LATENCY 2 and 0) checked every cycle against a
// transaction-timing reference model, with directed scenarios followed by random traffic.
module tb_mem_arbiter;

  localparam int ND = 2;
  localparam int unsigned LAT0 = 2;
  localparam int unsigned LAT1 = 0;

  logic clock = 1'b0;
  logic reset;

  logic        ifu_v  [ND];
  logic        ifu_r  [ND];
  logic [31:0] ifu_a  [ND];
  logic        ifu_rv [ND];
  logic [31:0] ifu_rd [ND];
  logic        lsu_v  [ND];
  logic        lsu_r  [ND];
  logic        lsu_w  [ND];
  logic [31:0] lsu_a  [ND];
  logic [31:0] lsu_wd [ND];
  logic [3:0]  lsu_ws [ND];
  logic        lsu_rv [ND];
  logic [31:0] lsu_rd [ND];
  logic        m_en   [ND];
  logic        m_wr   [ND];
  logic [31:0] m_addr [ND];
  logic [31:0] m_wd   [ND];
  logic [3:0]  m_ws   [ND];
  logic [31:0] m_rd   [ND];

  always #5 clock = ~clock;

  // Stateless memory contents: one fixed instruction word, a hash elsewhere
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? int'(LAT0) : int'(LAT1);
  endfunction

  for (genvar g = 0; g < ND; g++) begin : g_dut
    assign m_rd[g] = memf(m_addr[g]);
    mem_arbiter #(.LATENCY(g == 0 ? LAT0 : LAT1)) u_dut (
      .clock          (clock),
      .reset          (reset),
      .ifu_req_valid  (ifu_v[g]),
      .ifu_req_ready  (ifu_r[g]),
      .ifu_addr       (ifu_a[g]),
      .ifu_resp_valid (ifu_rv[g]),
      .ifu_rdata      (ifu_rd[g]),
      .lsu_req_valid  (lsu_v[g]),
      .lsu_req_ready  (lsu_r[g]),
      .lsu_wr         (lsu_w[g]),
      .lsu_addr       (lsu_a[g]),
      .lsu_wdata      (lsu_wd[g]),
      .lsu_wstrb      (lsu_ws[g]),
      .lsu_resp_valid (lsu_rv[g]),
      .lsu_rdata      (lsu_rd[g]),
      .mem_en         (m_en[g]),
      .mem_wr         (m_wr[g]),
      .mem_addr       (m_addr[g]),
      .mem_wdata      (m_wd[g]),
      .mem_wstrb      (m_ws[g]),
      .mem_rdata      (m_rd[g])
    );
  end

  // Reference model: at most one transaction in flight, accepted in cycle ta
  bit          busy  [ND];
  int          ta    [ND];
  bit          own   [ND];
  logic [31:0] x_addr[ND];
  logic [31:0] x_wd  [ND];
  bit          x_wr  [ND];
  logic [3:0]  x_ws  [ND];
  logic [31:0] x_ird [ND];
  logic [31:0] x_lrd [ND];
  bit          last  [ND];
  bit          acc_i [ND];
  bit          acc_l [ND];
  int          hold_i[ND];
  int          hold_l[ND];
  int          en_cnt[ND], en_cyc[ND];
  int          ir_cnt[ND], ir_cyc[ND];
  int          lr_cnt[ND], lr_cyc[ND];
  int          ib_t[$];
  logic [31:0] ib_dat[$];
  bit          grant_log[$];
  int          cyc;
  int          tests;
  int          fails;
  bit          rnd_en;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      busy[d] = 1'b0; ta[d] = 0; own[d] = 1'b0; last[d] = 1'b0;
      x_addr[d] = '0; x_wd[d] = '0; x_wr[d] = 1'b0; x_ws[d] = '0;
      x_ird[d] = '0; x_lrd[d] = '0; acc_i[d] = 1'b0; acc_l[d] = 1'b0;
    end
  endtask

  task automatic model_out(input int d, output bit e_ir, output bit e_lr, output bit e_iv,
                           output bit e_lv, output bit e_en, output bit e_wr, output logic [3:0] e_ws);
    int k;
    bit free, gl;
    k    = cyc - ta[d];
    free = !busy[d] || (k == lat_of(d) + 2);
    gl   = lsu_v[d];
`ifdef MEM_ARB_RR_EN
    if (ifu_v[d] && lsu_v[d]) gl = (last[d] == 1'b0);
`endif
    e_ir = reset && free && ifu_v[d] && !gl;
    e_lr = reset && free && lsu_v[d] && gl;
    e_iv = busy[d] && (k == lat_of(d) + 2) && !own[d];
    e_lv = busy[d] && (k == lat_of(d) + 2) && own[d];
    e_en = busy[d] && (k == lat_of(d) + 1);
    e_wr = e_en && x_wr[d];
    e_ws = e_en ? x_ws[d] : 4'h0;
  endtask

  task automatic model_update(input int d);
    bit e_ir, e_lr, e_iv, e_lv, e_en, e_wr;
    logic [3:0] e_ws;
    model_out(d, e_ir, e_lr, e_iv, e_lv, e_en, e_wr, e_ws);
    acc_i[d] = e_ir;
    acc_l[d] = e_lr;
    if (e_en) begin
      if (own[d]) x_lrd[d] = x_wr[d] ? 32'h0 : memf(x_addr[d]);
      else        x_ird[d] = memf(x_addr[d]);
    end
    if (e_iv || e_lv) busy[d] = 1'b0;
    if (e_ir || e_lr) begin
      busy[d]   = 1'b1;
      ta[d]     = cyc;
      own[d]    = e_lr;
      last[d]   = e_lr;
      x_addr[d] = e_lr ? lsu_a[d] : ifu_a[d];
      x_wr[d]   = e_lr && lsu_w[d];
      x_wd[d]   = e_lr ? lsu_wd[d] : 32'h0;
      x_ws[d]   = e_lr ? lsu_ws[d] : 4'h0;
      if (d == 0) grant_log.push_back(e_lr);
    end
  endtask

  task automatic check_dut(input int d);
    bit e_ir, e_lr, e_iv, e_lv, e_en, e_wr;
    logic [3:0] e_ws;
    model_out(d, e_ir, e_lr, e_iv, e_lv, e_en, e_wr, e_ws);
    chk($sformatf("hs d%0d c%0d", d, cyc), 72'({ifu_r[d], lsu_r[d], ifu_rv[d], lsu_rv[d]}),
        72'({e_ir, e_lr, e_iv, e_lv}));
    chk($sformatf("mem d%0d c%0d", d, cyc), 72'({m_en[d], m_wr[d], m_ws[d], m_addr[d], m_wd[d]}),
        72'({e_en, e_wr, e_ws, x_addr[d], x_wd[d]}));
    chk($sformatf("rdata d%0d c%0d", d, cyc), 72'({ifu_rd[d], lsu_rd[d]}), 72'({x_ird[d], x_lrd[d]}));
  endtask

  task automatic clr_log();
    for (int d = 0; d < ND; d++) begin
      en_cnt[d] = 0; en_cyc[d] = -1; ir_cnt[d] = 0; ir_cyc[d] = -1; lr_cnt[d] = 0; lr_cyc[d] = -1;
    end
    ib_t.delete();
    ib_dat.delete();
  endtask

  // One clock: check at negedge, advance model at posedge, then requesters react
  task automatic cycle();
    @(negedge clock);
    for (int d = 0; d < ND; d++) begin
      if (m_en[d])   begin en_cnt[d]++; en_cyc[d] = cyc; end
      if (lsu_rv[d]) begin lr_cnt[d]++; lr_cyc[d] = cyc; end
      if (ifu_rv[d]) begin
        ir_cnt[d]++; ir_cyc[d] = cyc;
        if (d == 1) begin ib_t.push_back(cyc); ib_dat.push_back(ifu_rd[d]); end
      end
      check_dut(d);
    end
    @(posedge clock);
    for (int d = 0; d < ND; d++) begin
      if (reset) model_update(d);
      else begin acc_i[d] = 1'b0; acc_l[d] = 1'b0; end
    end
    cyc++;
    #1;
    for (int d = 0; d < ND; d++) begin
      if (acc_i[d]) begin
        if (hold_i[d] > 0) begin hold_i[d]--; ifu_a[d] = ifu_a[d] + 32'd4; end
        else ifu_v[d] = 1'b0;
      end
      if (acc_l[d]) begin
        if (hold_l[d] > 0) begin hold_l[d]--; lsu_a[d] = lsu_a[d] + 32'd4; end
        else lsu_v[d] = 1'b0;
      end
      if (rnd_en && !ifu_v[d] && ($urandom_range(0, 2) == 0)) begin
        ifu_v[d] = 1'b1;
        ifu_a[d] = $urandom;
      end
      if (rnd_en && !lsu_v[d] && ($urandom_range(0, 2) == 0)) begin
        lsu_v[d]  = 1'b1;
        lsu_w[d]  = 1'(($urandom >> 3) & 1);
        lsu_a[d]  = $urandom;
        lsu_wd[d] = $urandom;
        lsu_ws[d] = 4'($urandom);
      end
    end
  endtask

  task automatic set_ifu(input logic [31:0] a);
    for (int d = 0; d < ND; d++) begin ifu_v[d] = 1'b1; ifu_a[d] = a; end
  endtask

  task automatic set_lsu(input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    for (int d = 0; d < ND; d++) begin
      lsu_v[d] = 1'b1; lsu_w[d] = wr; lsu_a[d] = a; lsu_wd[d] = wd; lsu_ws[d] = ws;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    bit first_lsu;
    bit exp_order [4];
    tests = 0; fails = 0; cyc = 0; rnd_en = 1'b0;
    reset = 1'b0;
    for (int d = 0; d < ND; d++) begin
      ifu_v[d] = 1'b1; ifu_a[d] = 32'h0; lsu_v[d] = 1'b1; lsu_w[d] = 1'b0;
      lsu_a[d] = 32'h0; lsu_wd[d] = 32'h0; lsu_ws[d] = 4'h0; hold_i[d] = 0; hold_l[d] = 0;
    end
    model_reset();
    clr_log();
    // Reset holds all outputs low even with both requesters valid
    cycle();
    cycle();
    for (int d = 0; d < ND; d++) begin ifu_v[d] = 1'b0; lsu_v[d] = 1'b0; end
    @(negedge clock);
    reset = 1'b1;
    cycle();

    // IFU read
    clr_log();
    set_ifu(32'h8000_0000);
    t0 = cyc;
    repeat (7) cycle();
    chk("ifu rd en cycle", 72'(en_cyc[0] - t0), 72'(3));
    chk("ifu rd en count", 72'(en_cnt[0]), 72'(1));
    chk("ifu rd resp cycle", 72'(ir_cyc[0] - t0), 72'(4));
    chk("ifu rd data", 72'(ifu_rd[0]), 72'(32'h0000_0413));
    chk("ifu rd no lsu resp", 72'(lr_cnt[0]), 72'(0));
    chk("ifu rd lat0 resp cycle", 72'(ir_cyc[1] - t0), 72'(2));

    // LSU write
    clr_log();
    set_lsu(1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'h3);
    t0 = cyc;
    repeat (7) cycle();
    chk("lsu wr en count", 72'(en_cnt[0]), 72'(1));
    chk("lsu wr resp cycle", 72'(lr_cyc[0] - t0), 72'(4));
    chk("lsu wr rdata", 72'(lsu_rd[0]), 72'(0));
    chk("lsu wr no ifu resp", 72'(ir_cnt[0]), 72'(0));

    // Contention
    clr_log();
`ifdef MEM_ARB_RR_EN
    first_lsu = 1'b0;
`else
    first_lsu = 1'b1;
`endif
    set_ifu(32'h0000_0100);
    set_lsu(1'b0, 32'h0000_0200, 32'h0, 4'h0);
    t0 = cyc;
    repeat (11) cycle();
    chk("contend first resp", 72'(first_lsu ? lr_cyc[0] - t0 : ir_cyc[0] - t0), 72'(4));
    chk("contend second resp", 72'(first_lsu ? ir_cyc[0] - t0 : lr_cyc[0] - t0), 72'(8));
    chk("contend lsu data", 72'(lsu_rd[0]), 72'(memf(32'h0000_0200)));
    chk("contend ifu data", 72'(ifu_rd[0]), 72'(memf(32'h0000_0100)));

    // Back-to-back IFU reads, checked on the zero-latency instance
    clr_log();
    set_ifu(32'h0000_1000);
    for (int d = 0; d < ND; d++) hold_i[d] = 2;
    t0 = cyc;
    repeat (16) cycle();
    chk("b2b count", 72'(ib_t.size()), 72'(3));
    for (int i = 0; i < 3 && i < ib_t.size(); i++) begin
      chk($sformatf("b2b t%0d", i), 72'(ib_t[i] - t0), 72'(2 * i + 2));
      chk($sformatf("b2b d%0d", i), 72'(ib_dat[i]), 72'(memf(32'h0000_1000 + 32'(4 * i))));
    end

    // Reset during WAIT
    set_ifu(32'h0000_2000);
    cycle();
    cycle();
    @(negedge clock);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < ND; d++) check_dut(d);
    chk("rst mid mem_en", 72'(m_en[0]), 72'(0));
    @(posedge clock);
    cyc++;
    @(negedge clock);
    #2;
    reset = 1'b1;
    clr_log();
    repeat (8) cycle();
    chk("rst dropped no resp", 72'(ir_cnt[0] + ir_cnt[1]), 72'(0));
    chk("rst dropped no access", 72'(en_cnt[0] + en_cnt[1]), 72'(0));
    set_ifu(32'h0000_3000);
    repeat (6) cycle();
    chk("post rst resp", 72'(ir_cnt[0]), 72'(1));
    chk("post rst data", 72'(ifu_rd[0]), 72'(memf(32'h0000_3000)));

    // Both requesters continuously valid: grant order
    grant_log.delete();
`ifdef MEM_ARB_RR_EN
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    set_ifu(32'h0000_4000);
    set_lsu(1'b0, 32'h0000_5000, 32'h0, 4'h0);
    for (int d = 0; d < ND; d++) begin hold_i[d] = 8; hold_l[d] = 8; end
    for (int i = 0; i < 60 && grant_log.size() < 4; i++) cycle();
    chk("order count", 72'(grant_log.size() >= 4), 72'(1));
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      chk($sformatf("order %0d", i), 72'(grant_log[i]), 72'(exp_order[i]));
    for (int d = 0; d < ND; d++) begin hold_i[d] = 0; hold_l[d] = 0; end
    repeat (20) cycle();

    // Random traffic
    rnd_en = 1'b1;
    repeat (600) cycle();
    rnd_en = 1'b0;
    repeat (30) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
